// File: rtl/codec_register_bank.sv
// CODEC-unit register bank: I2C command mailbox, W1C sticky status with maskable IRQ,
// and per-channel FIFO occupancy sampling with peak-hold and hi/lo watermark flags.
module codec_register_bank #(
    parameter int OPT_MEM_ADDR_BITS = 6,
    parameter int NUM_CH            = 4,
    parameter int CNT_W             = 16
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset,
    input  logic [31:0]                  data_in,
    output logic [31:0]                  data_out,
    input  logic [OPT_MEM_ADDR_BITS-1:0] reg_addr_wr,
    input  logic [OPT_MEM_ADDR_BITS-1:0] reg_addr_rd,
    input  logic                         data_wren,
    input  logic [3:0]                   byte_enable,
    output logic                         i2c_wr_req,
    output logic                         i2c_rd_req,
    input  logic                         i2c_busy,
    input  logic                         i2c_done,
    input  logic                         i2c_rd_valid,
    input  logic [31:0]                  i2c_rd_data,
    input  logic                         init_done,
    input  logic                         missed_ack,
    output logic [31:0]                  i2c_addr,
    output logic [31:0]                  i2c_wr_data,
    output logic                         controller_reset,
    input  logic [32*NUM_CH-1:0]         fifo_count,
    output logic                         irq
);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_CTRL    = OPT_MEM_ADDR_BITS'(0);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_STATUS  = OPT_MEM_ADDR_BITS'(1);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_IRQ_EN  = OPT_MEM_ADDR_BITS'(2);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_I2C_ADR = OPT_MEM_ADDR_BITS'(3);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_I2C_WD  = OPT_MEM_ADDR_BITS'(4);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_I2C_RD  = OPT_MEM_ADDR_BITS'(5);
    localparam logic [OPT_MEM_ADDR_BITS-1:0] A_WMARK   = OPT_MEM_ADDR_BITS'(6);
    localparam int                           A_CNT0    = 16;
    localparam logic [31:0]                  RD_DATA_RST = 32'hCAFE_CAFE;
    localparam logic [31:0]                  WMARK_RST   = 32'hFFFF_0000;

    logic [31:0]         be_mask;
    logic                wr_ctrl, wr_status, wr_irq_en, wr_i2c_adr, wr_i2c_wd, wr_wmark;
    logic [1:0]          req_set;
    logic                cmd_reject, cmd_accept;
    logic                busy_q;
    logic [31:0]         status, irq_en, rd_data, wmark;
    logic [31:0]         status_set, status_valid, status_clr;
    logic [CNT_W-1:0]    hi_lim, lo_lim;
    logic [NUM_CH*CNT_W-1:0] cnt_flat, peak_flat;
    logic [NUM_CH-1:0]   hi_flag, lo_flag;

    assign be_mask    = {{8{byte_enable[3]}}, {8{byte_enable[2]}}, {8{byte_enable[1]}}, {8{byte_enable[0]}}};
    assign wr_ctrl    = data_wren && (reg_addr_wr == A_CTRL);
    assign wr_status  = data_wren && (reg_addr_wr == A_STATUS);
    assign wr_irq_en  = data_wren && (reg_addr_wr == A_IRQ_EN);
    assign wr_i2c_adr = data_wren && (reg_addr_wr == A_I2C_ADR);
    assign wr_i2c_wd  = data_wren && (reg_addr_wr == A_I2C_WD);
    assign wr_wmark   = data_wren && (reg_addr_wr == A_WMARK);

    // Mailbox handshake: SW raises a req bit (W1S) only when the controller is idle and no
    // request is outstanding; the req level holds until the controller pulses i2c_done.
    // A request attempted at any other time is dropped and flagged as cmd_reject.
    assign req_set    = data_in[1:0] & {2{byte_enable[0] & wr_ctrl}};
    assign cmd_reject = (|req_set) && (i2c_busy || i2c_wr_req || i2c_rd_req);
    assign cmd_accept = (|req_set) && !cmd_reject;

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            i2c_wr_req       <= 1'b0;
            i2c_rd_req       <= 1'b0;
            controller_reset <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            busy_q <= i2c_busy;
            if (cmd_accept) begin
                i2c_wr_req <= req_set[0];
                i2c_rd_req <= req_set[1];
            end else if (i2c_done) begin
                i2c_wr_req <= 1'b0;
                i2c_rd_req <= 1'b0;
            end
            if (init_done)
                controller_reset <= 1'b0;
            else if (wr_ctrl && byte_enable[3] && data_in[31])
                controller_reset <= 1'b1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            irq_en      <= '0;
            i2c_addr    <= '0;
            i2c_wr_data <= '0;
            wmark       <= WMARK_RST;
            rd_data     <= RD_DATA_RST;
        end else begin
            if (wr_irq_en)  irq_en      <= (irq_en & ~be_mask) | (data_in & be_mask);
            if (wr_i2c_adr) i2c_addr    <= (i2c_addr & ~be_mask) | (data_in & be_mask);
            if (wr_i2c_wd)  i2c_wr_data <= (i2c_wr_data & ~be_mask) | (data_in & be_mask);
            if (wr_wmark)   wmark       <= (wmark & ~be_mask) | (data_in & be_mask);
            if (i2c_rd_valid)
                rd_data <= i2c_rd_data;
            else if (cmd_accept && req_set[1])
                rd_data <= RD_DATA_RST;
        end
    end

    assign hi_lim = wmark[16 +: CNT_W];
    assign lo_lim = wmark[0 +: CNT_W];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [31:0]      raw;
        logic [CNT_W-1:0] sat, cnt_q, peak_q;
        logic             wr_peak;

        assign raw     = fifo_count[32*i +: 32];
        assign wr_peak = data_wren && (reg_addr_wr == OPT_MEM_ADDR_BITS'(A_CNT0 + 2*i + 1));

        always_comb begin
            sat = raw[CNT_W-1:0];
            if (|(raw >> CNT_W)) sat = '1;
        end

        always_ff @(posedge axi_clk or negedge axi_reset) begin
            if (!axi_reset) begin
                cnt_q  <= '0;
                peak_q <= '0;
            end else begin
                cnt_q <= sat;
                if (wr_peak)
                    peak_q <= cnt_q;
                else if (cnt_q > peak_q)
                    peak_q <= cnt_q;
            end
        end

        assign cnt_flat[i*CNT_W +: CNT_W]  = cnt_q;
        assign peak_flat[i*CNT_W +: CNT_W] = peak_q;
        assign hi_flag[i] = cnt_q >= hi_lim;
        assign lo_flag[i] = cnt_q <= lo_lim;
    end

    always_comb begin
        status_set      = '0;
        status_valid    = '0;
        status_set[0]   = init_done;
        status_set[1]   = i2c_rd_valid;
        status_set[2]   = missed_ack;
        status_set[3]   = cmd_reject;
        status_valid[3:0] = 4'hF;
        for (int i = 0; i < NUM_CH; i++) begin
            status_set[8+i]    = hi_flag[i];
            status_set[16+i]   = lo_flag[i];
            status_valid[8+i]  = 1'b1;
            status_valid[16+i] = 1'b1;
        end
    end

    assign status_clr = wr_status ? (data_in & be_mask) : '0;

    // Set beats clear, so a level watermark flag that is still true re-asserts at once.
    always_ff @(posedge axi_clk or negedge axi_reset) begin
        if (!axi_reset) begin
            status <= '0;
            irq    <= 1'b0;
        end else begin
            status <= ((status & ~status_clr) | status_set) & status_valid;
            irq    <= |(status & irq_en);
        end
    end

    always_comb begin
        data_out = 32'hDEAD_BEEF;
        case (reg_addr_rd)
            A_CTRL:    data_out = {controller_reset, 28'd0, busy_q, i2c_rd_req, i2c_wr_req};
            A_STATUS:  data_out = status;
            A_IRQ_EN:  data_out = irq_en;
            A_I2C_ADR: data_out = i2c_addr;
            A_I2C_WD:  data_out = i2c_wr_data;
            A_I2C_RD:  data_out = rd_data;
            A_WMARK:   data_out = wmark;
            default:   ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (reg_addr_rd == OPT_MEM_ADDR_BITS'(A_CNT0 + 2*i))
                data_out = {{(32-CNT_W){1'b0}}, cnt_flat[i*CNT_W +: CNT_W]};
            if (reg_addr_rd == OPT_MEM_ADDR_BITS'(A_CNT0 + 2*i + 1))
                data_out = {{(32-CNT_W){1'b0}}, peak_flat[i*CNT_W +: CNT_W]};
        end
    end

endmodule

// File: tb/tb_codec_register_bank.sv
// Self-checking bench for codec_register_bank: register map, byte enables, mailbox
// handshake, W1C status/IRQ timing and FIFO count sampling with peak/watermarks.
module tb_codec_register_bank;
    localparam int AW  = 6;
    localparam int NCH = 4;
    localparam int CW  = 16;

    logic              axi_clk = 1'b0;
    logic              axi_reset;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic [AW-1:0]     reg_addr_wr, reg_addr_rd;
    logic              data_wren;
    logic [3:0]        byte_enable;
    logic              i2c_wr_req, i2c_rd_req;
    logic              i2c_busy, i2c_done, i2c_rd_valid;
    logic [31:0]       i2c_rd_data;
    logic              init_done, missed_ack;
    logic [31:0]       i2c_addr, i2c_wr_data;
    logic              controller_reset;
    logic [32*NCH-1:0] fifo_count;
    logic              irq;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    codec_register_bank #(.OPT_MEM_ADDR_BITS(AW), .NUM_CH(NCH), .CNT_W(CW)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .data_in(data_in), .data_out(data_out),
        .reg_addr_wr(reg_addr_wr), .reg_addr_rd(reg_addr_rd), .data_wren(data_wren),
        .byte_enable(byte_enable), .i2c_wr_req(i2c_wr_req), .i2c_rd_req(i2c_rd_req),
        .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_rd_valid(i2c_rd_valid),
        .i2c_rd_data(i2c_rd_data), .init_done(init_done), .missed_ack(missed_ack),
        .i2c_addr(i2c_addr), .i2c_wr_data(i2c_wr_data), .controller_reset(controller_reset),
        .fifo_count(fifo_count), .irq(irq)
    );

    // clock / reset
    always #5 axi_clk = ~axi_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // driver tasks: every task starts and ends 1ns after a rising edge
    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic reg_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
        reg_addr_wr = addr;
        data_in     = data;
        byte_enable = be;
        data_wren   = 1'b1;
        tick();
        data_wren   = 1'b0;
    endtask

    // scoreboard: expected value queued with the read request, popped when data_out settles
    task automatic reg_expect(input string tag, input logic [AW-1:0] addr,
                              input logic [31:0] mask, input logic [31:0] exp);
        logic [31:0] got;
        exp_q.push_back(exp & mask);
        reg_addr_rd = addr;
        #1;
        got = data_out & mask;
        check(tag, got, exp_q.pop_front());
    endtask

    function automatic logic [31:0] reset_val(input int a);
        if (a == 5) return 32'hCAFE_CAFE;
        if (a == 6) return 32'hFFFF_0000;
        if (a <= 6) return 32'h0;
        if (a >= 16 && a < 16 + 2*NCH) return 32'h0;
        return 32'hDEAD_BEEF;
    endfunction

    initial begin
        axi_reset = 1'b0;
        data_in = '0; reg_addr_wr = '0; reg_addr_rd = '0; data_wren = 1'b0; byte_enable = '0;
        i2c_busy = 1'b0; i2c_done = 1'b0; i2c_rd_valid = 1'b0; i2c_rd_data = '0;
        init_done = 1'b0; missed_ack = 1'b0; fifo_count = '0;
        tick();
        tick();

        // reset state
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_wr_req", 32'(i2c_wr_req), 32'h0);
        check("rst_ctrl_reset", 32'(controller_reset), 32'h0);
        check("rst_i2c_addr", i2c_addr, 32'h0);
        for (int a = 0; a < 16 + 2*NCH; a++)
            reg_expect($sformatf("rst_rd_%02h", a), AW'(a), 32'hFFFF_FFFF, reset_val(a));
        reg_expect("rst_rd_3f", AW'(63), 32'hFFFF_FFFF, reset_val(63));
        axi_reset = 1'b1;
        tick();

        // byte enables
        reg_write(AW'(4), 32'h1122_3344, 4'b0101);
        reg_expect("be_first", AW'(4), 32'hFFFF_FFFF, 32'h0022_0044);
        reg_write(AW'(4), 32'hFFFF_FFFF, 4'b0010);
        reg_expect("be_second", AW'(4), 32'hFFFF_FFFF, 32'h0022_FF44);
        check("i2c_wr_data_port", i2c_wr_data, 32'h0022_FF44);
        reg_write(AW'(3), 32'h0000_0050 + 32'($urandom_range(0, 15)), 4'b0001);
        check("i2c_addr_port_hi", i2c_addr & 32'hFFFF_FFF0, 32'h0000_0050);

        // W1S bit outside enabled bytes is ignored and not rejected
        reg_write(AW'(0), 32'h0000_0001, 4'b1110);
        check("be_w1s_ignored", 32'(i2c_wr_req), 32'h0);
        reg_expect("be_no_reject", AW'(1), 32'h0000_0008, 32'h0);

        // read command with captured data
        reg_write(AW'(0), 32'h0000_0002, 4'hF);
        check("rd_req_set", 32'(i2c_rd_req), 32'h1);
        reg_expect("ctrl_rd_req", AW'(0), 32'hFFFF_FFFF, 32'h0000_0002);
        reg_expect("rd_data_reload", AW'(5), 32'hFFFF_FFFF, 32'hCAFE_CAFE);
        i2c_rd_data = 32'h0000_00A5; i2c_rd_valid = 1'b1;
        tick();
        i2c_rd_valid = 1'b0;
        reg_expect("rd_data_capture", AW'(5), 32'hFFFF_FFFF, 32'h0000_00A5);
        reg_expect("status_rd_valid", AW'(1), 32'h0000_0002, 32'h0000_0002);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        check("rd_req_done", 32'(i2c_rd_req), 32'h0);
        reg_expect("ctrl_after_done", AW'(0), 32'hFFFF_FFFF, 32'h0);
        reg_write(AW'(0), 32'h0000_0002, 4'hF);
        reg_expect("rd_data_reload2", AW'(5), 32'hFFFF_FFFF, 32'hCAFE_CAFE);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;

        // busy reject and IRQ timing
        i2c_busy = 1'b1;
        tick();
        reg_expect("ctrl_busy_lag", AW'(0), 32'hFFFF_FFFF, 32'h0000_0004);
        reg_write(AW'(0), 32'h0000_0001, 4'hF);
        check("reject_wr_req", 32'(i2c_wr_req), 32'h0);
        reg_expect("status_reject", AW'(1), 32'h0000_0008, 32'h0000_0008);
        reg_write(AW'(2), 32'h0000_0008, 4'hF);
        check("irq_lag", 32'(irq), 32'h0);
        tick();
        check("irq_set", 32'(irq), 32'h1);
        reg_write(AW'(1), 32'h0000_0008, 4'hF);
        check("irq_hold_after_w1c", 32'(irq), 32'h1);
        tick();
        check("irq_clear", 32'(irq), 32'h0);
        i2c_busy = 1'b0;

        // FIFO count sampling on channel 2
        reg_write(AW'(6), 32'h0100_000A, 4'hF);
        fifo_count[64 +: 32] = 32'd5;
        tick(); tick();
        reg_expect("cnt2_5", AW'(20), 32'hFFFF_FFFF, 32'd5);
        reg_expect("peak2_5", AW'(21), 32'hFFFF_FFFF, 32'd5);
        reg_expect("status_lo2", AW'(1), 32'h0004_0400, 32'h0004_0000);
        fifo_count[64 +: 32] = 32'd300;
        tick(); tick();
        reg_expect("cnt2_300", AW'(20), 32'hFFFF_FFFF, 32'd300);
        reg_expect("status_hi2", AW'(1), 32'h0000_0400, 32'h0000_0400);
        fifo_count[64 +: 32] = 32'h0001_0007;
        tick(); tick();
        reg_expect("cnt2_sat", AW'(20), 32'hFFFF_FFFF, 32'h0000_FFFF);
        reg_expect("peak2_sat", AW'(21), 32'hFFFF_FFFF, 32'h0000_FFFF);
        reg_expect("status_hi_lo2", AW'(1), 32'h0004_0400, 32'h0004_0400);
        reg_expect("cnt1_zero", AW'(18), 32'hFFFF_FFFF, 32'h0);
        reg_write(AW'(1), 32'h0000_0400, 4'hF);
        reg_expect("status_hi_reset", AW'(1), 32'h0000_0400, 32'h0000_0400);
        reg_write(AW'(1), 32'h0004_0000, 4'hF);
        reg_expect("status_lo_clear", AW'(1), 32'h0004_0000, 32'h0);
        fifo_count[64 +: 32] = 32'd3;
        tick();
        reg_write(AW'(21), 32'h0, 4'hF);
        reg_expect("peak2_load", AW'(21), 32'hFFFF_FFFF, 32'd3);
        tick();
        reg_expect("peak2_hold", AW'(21), 32'hFFFF_FFFF, 32'd3);

        // same-cycle priorities
        reg_addr_wr = AW'(0); data_in = 32'h1; byte_enable = 4'hF; data_wren = 1'b1; i2c_done = 1'b1;
        tick();
        data_wren = 1'b0; i2c_done = 1'b0;
        check("set_wins_done", 32'(i2c_wr_req), 32'h1);
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        check("wr_req_done", 32'(i2c_wr_req), 32'h0);
        reg_addr_wr = AW'(1); data_in = 32'h4; byte_enable = 4'hF; data_wren = 1'b1; missed_ack = 1'b1;
        tick();
        data_wren = 1'b0; missed_ack = 1'b0;
        reg_expect("nack_set_wins", AW'(1), 32'h0000_0004, 32'h0000_0004);
        reg_write(AW'(1), 32'h0000_0004, 4'hF);
        reg_expect("nack_w1c", AW'(1), 32'h0000_0004, 32'h0);
        reg_write(AW'(0), 32'h8000_0000, 4'hF);
        check("ctrl_reset_set", 32'(controller_reset), 32'h1);
        reg_addr_wr = AW'(0); data_in = 32'h8000_0000; byte_enable = 4'hF; data_wren = 1'b1; init_done = 1'b1;
        tick();
        data_wren = 1'b0; init_done = 1'b0;
        check("init_clear_wins", 32'(controller_reset), 32'h0);
        reg_expect("status_init", AW'(1), 32'h0000_0001, 32'h0000_0001);

        // async reset mid-transaction
        reg_write(AW'(0), 32'h0000_0001, 4'hF);
        check("wr_req_before_rst", 32'(i2c_wr_req), 32'h1);
        #2 axi_reset = 1'b0;
        #1;
        check("async_rst_req", 32'(i2c_wr_req), 32'h0);
        #3 axi_reset = 1'b1;
        tick();
        i2c_done = 1'b1;
        tick();
        i2c_done = 1'b0;
        check("done_after_rst", 32'(i2c_wr_req), 32'h0);
        reg_expect("rd_data_after_rst", AW'(5), 32'hFFFF_FFFF, 32'hCAFE_CAFE);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
